// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART TX byte port
// between NUM_REQ requesters, with an optional inter-byte lock timeout.

module uart_tx_arb_lane (
  input  logic en,
  input  logic idle,
  input  logic fetch,
  input  logic win,
  input  logic owner,
  output logic ready
);
  // IDLE offers the slot to the arbitration winner; FETCH only to the owner
  assign ready = en & ((idle & win) | (fetch & owner));
endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   timeout_err
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, FETCH} state_t;

  state_t                    state, state_n;
  logic [1:0]                last_grant, winner, sel, hi_idx, lo_idx;
  logic                      hi_hit, lo_hit, any_valid, own_valid;
  logic [NUM_REQ-1:0]        win_oh, owner_oh;
  logic [NUM_REQ-1:0][7:0]   data_arr;
  logic [7:0]                cap_data;
  logic                      cap_last, hold_last;
  logic                      capture, release_lock, expire;
  logic [CW-1:0]             cnt, cnt_n;

  assign data_arr = req_data;

  // Requesters above last_grant come first, then wrap to the lowest index
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (2'(i) > last_grant) begin
          hi_hit = 1'b1;
          hi_idx = 2'(i);
        end else begin
          lo_hit = 1'b1;
          lo_idx = 2'(i);
        end
      end
    end
    any_valid = hi_hit | lo_hit;
    winner    = hi_hit ? hi_idx : lo_idx;
  end

  always_comb begin
    win_oh   = '0;
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i]   = any_valid && (winner == 2'(i));
      owner_oh[i] = (grant_id == 2'(i));
    end
  end

  assign own_valid = |(req_valid & owner_oh);
  assign sel       = (state == IDLE) ? winner : grant_id;

  always_comb begin
    cap_data = '0;
    cap_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == 2'(i)) begin
        cap_data = data_arr[i];
        cap_last = req_last[i];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      uart_tx_arb_lane u_lane (
        .en    (~reset),
        .idle  (state == IDLE),
        .fetch (state == FETCH),
        .win   (win_oh[g]),
        .owner (owner_oh[g]),
        .ready (req_ready[g])
      );
    end
  endgenerate

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    capture      = 1'b0;
    release_lock = 1'b0;
    expire       = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          capture = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (hold_last) begin
            state_n      = IDLE;
            release_lock = 1'b1;
          end else begin
            state_n = FETCH;
            cnt_n   = '0;
          end
        end
      end
      FETCH: begin
        // A byte arriving on the expiry cycle still wins over the timeout
        if (own_valid) begin
          capture = 1'b1;
          state_n = SEND;
        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT)) begin
          state_n      = IDLE;
          release_lock = 1'b1;
          expire       = 1'b1;
        end else if (cnt != '1) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 2'(NUM_REQ - 1);
      cnt         <= '0;
      tx_data     <= '0;
      hold_last   <= 1'b0;
      grant_id    <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      tx_valid    <= (state_n == SEND);
      busy        <= (state_n != IDLE);
      timeout_err <= expire;
      if (capture) begin
        tx_data   <= cap_data;
        hold_last <= cap_last;
        grant_id  <= sel;
      end
      if (release_lock)
        last_grant <= grant_id;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected TX bytes are queued as stimulus
// is driven and compared when the TX handshake completes.

module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 3;
  localparam int TIMEOUT = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready = 1'b0;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic l);
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
  endtask

  // Scoreboard compare at the falling edge, then step past the next rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed byte %0h expected none", tx_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 32'(tx_data), 32'(e.data));
        check("sb_grant", 32'(grant_id), 32'(e.id));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tmo", 32'(timeout_err), 0);
    reset = 1'b0;

    // Single byte with TX back-pressure
    set_req(0, 8'h41, 1'b1);
    req_valid = 3'b001;
    #1;
    check("single_ready", 32'(req_ready), 32'b001);
    push(0, 8'h41);
    tick();
    req_valid = '0;
    #1;
    check("single_tx_valid", 32'(tx_valid), 1);
    check("single_tx_data", 32'(tx_data), 32'h41);
    check("single_busy", 32'(busy), 1);
    check("single_send_ready", 32'(req_ready), 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("single_hold", 32'(tx_data), 32'h41);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("single_busy_off", 32'(busy), 0);
    check("single_txv_off", 32'(tx_valid), 0);

    // Round-robin from a fresh pointer
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(8'hA0 + i), 1'b1);
    req_valid = 3'b111;
    tx_ready  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      push(k % 3, 8'(8'hA0 + k % 3));
      tick();
      check("rr_grant", 32'(grant_id), 32'(k % 3));
      tick();
    end
    req_valid = '0;
    tx_ready  = 1'b0;

    // Packet lock: requester 1 keeps the port while requester 0 waits
    set_req(1, 8'h10, 1'b0);
    req_valid = 3'b010;
    push(1, 8'h10);
    tick();
    check("lock_grant", 32'(grant_id), 1);
    set_req(0, 8'h55, 1'b1);
    req_valid = 3'b011;
    tx_ready  = 1'b1;
    tick();
    set_req(1, 8'h11, 1'b0);
    #1;
    check("lock_fetch_ready", 32'(req_ready), 32'b010);
    push(1, 8'h11);
    tick();
    tick();
    set_req(1, 8'h12, 1'b1);
    #1;
    check("lock_fetch_ready2", 32'(req_ready), 32'b010);
    push(1, 8'h12);
    tick();
    req_valid = 3'b001;
    tick();
    #1;
    check("lock_next_ready", 32'(req_ready), 32'b001);
    push(0, 8'h55);
    tick();
    check("lock_next_grant", 32'(grant_id), 0);
    req_valid = '0;
    tick();
    tx_ready = 1'b0;

    // Timeout: requester 2 stalls mid-packet
    set_req(2, 8'h77, 1'b0);
    req_valid = 3'b100;
    push(2, 8'h77);
    tick();
    req_valid = '0;
    tx_ready  = 1'b1;
    tick();
    tx_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("tmo_pulse", 32'(timeout_err), 32'(c == 5));
      if (c == 4) check("tmo_busy_held", 32'(busy), 1);
      if (c == 5) check("tmo_busy_drop", 32'(busy), 0);
    end
    set_req(0, 8'h60, 1'b1);
    set_req(1, 8'h61, 1'b1);
    req_valid = 3'b011;
    #1;
    check("tmo_next_ready", 32'(req_ready), 32'b001);
    push(0, 8'h60);
    tick();
    check("tmo_next_grant", 32'(grant_id), 0);
    req_valid = '0;
    tx_ready  = 1'b1;
    tick();
    tx_ready = 1'b0;

    // Mid-packet asynchronous reset discards the held byte
    set_req(1, 8'h99, 1'b1);
    req_valid = 3'b010;
    tick();
    check("mid_tx_valid", 32'(tx_valid), 1);
    set_req(0, 8'hC0, 1'b1);
    req_valid = 3'b111;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_after_ready", 32'(req_ready), 32'b001);
    push(0, 8'hC0);
    tick();
    check("mid_after_grant", 32'(grant_id), 0);
    req_valid = '0;
    tx_ready  = 1'b1;
    tick();
    tx_ready = 1'b0;

    // Byte arrives on the same cycle the timeout would expire
    set_req(1, 8'h31, 1'b0);
    req_valid = 3'b010;
    push(1, 8'h31);
    tick();
    req_valid = '0;
    tx_ready  = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (4) tick();
    check("coll_still_locked", 32'(busy), 1);
    set_req(1, 8'h32, 1'b1);
    req_valid = 3'b010;
    push(1, 8'h32);
    tick();
    req_valid = '0;
    check("coll_tmo", 32'(timeout_err), 0);
    check("coll_tx_valid", 32'(tx_valid), 1);
    check("coll_tx_data", 32'(tx_data), 32'h32);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("coll_tmo_after", 32'(timeout_err), 0);
    check("coll_idle", 32'(busy), 0);

    check("sb_drain", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
